// File: rtl/mem_port_arbiter_if.sv
// Signal bundle around the shared RAM port: fetch stage, MEM stage and RAM side.
// The arbiter takes the master view and the surrounding pipeline/RAM takes the slave view.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 16
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_flush;
    logic                  if_ack;
    logic [WORD_WIDTH-1:0] if_rdata;

    logic                  ms_req;
    logic                  ms_we;
    logic [ADDR_WIDTH-1:0] ms_addr;
    logic [WORD_WIDTH-1:0] ms_wdata;
    logic                  ms_ack;
    logic [WORD_WIDTH-1:0] ms_rdata;
    logic                  stall;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [WORD_WIDTH-1:0] mem_rdata;
    logic                  bus_error;

    modport master (
        input  if_req, if_addr, if_flush,
        input  ms_req, ms_we, ms_addr, ms_wdata,
        input  mem_ack, mem_rdata,
        output if_ack, if_rdata, ms_ack, ms_rdata, stall,
        output mem_req, mem_we, mem_addr, mem_wdata, bus_error
    );

    modport slave (
        output if_req, if_addr, if_flush,
        output ms_req, ms_we, ms_addr, ms_wdata,
        output mem_ack, mem_rdata,
        input  if_ack, if_rdata, ms_ack, ms_rdata, stall,
        input  mem_req, mem_we, mem_addr, mem_wdata, bus_error
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the MEM stage: one transaction
// at a time, bounded fetch starvation, jump-flush discard and a sticky timeout error.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int WORD_WIDTH    = 16,
    parameter int MAX_MEM_BURST = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic               gclk,
    input  logic               reset,
    mem_port_arbiter_if.master bus
);
    localparam int BW = $clog2(MAX_MEM_BURST + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] BURST_MAX    = BW'(MAX_MEM_BURST);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_MS = 2'd2
    } state_t;

    state_t                state_r, state_s;
    logic                  mem_req_r, mem_req_s;
    logic                  mem_we_r, mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
    logic [WORD_WIDTH-1:0] mem_wdata_r, mem_wdata_s;
    logic                  if_ack_r, if_ack_s;
    logic                  ms_ack_r, ms_ack_s;
    logic [WORD_WIDTH-1:0] if_rdata_r, if_rdata_s;
    logic [WORD_WIDTH-1:0] ms_rdata_r, ms_rdata_s;
    logic                  bus_error_r, bus_error_s;
    logic [BW-1:0]         burst_cnt_r, burst_cnt_s;
    logic [TW-1:0]         timer_r, timer_s;
    logic                  if_kill_r, if_kill_s;
    logic                  flushed_r, flushed_s;
    logic [ADDR_WIDTH-1:0] if_addr_prev_r;
    logic                  if_pend_s;
    logic [WORD_WIDTH-1:0] done_rdata_s;

    // A flush in the same cycle already counts as invalidating the fetch.
    assign if_pend_s    = bus.if_req & ~if_kill_r & ~bus.if_flush;
    assign done_rdata_s = bus.mem_ack ? bus.mem_rdata : {WORD_WIDTH{1'b0}};

    // Discard latch: set by a flush of a live fetch, cleared once the fetch request moves on.
    always_comb begin
        if_kill_s = if_kill_r;
        if (bus.if_req && bus.if_flush) begin
            if_kill_s = 1'b1;
        end else if (!bus.if_req || (bus.if_addr != if_addr_prev_r)) begin
            if_kill_s = 1'b0;
        end else begin
            if_kill_s = if_kill_r;
        end
    end

    // Next-state and next-output logic for arbitration and transaction sequencing.
    always_comb begin
        state_s     = state_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        if_ack_s    = 1'b0;
        ms_ack_s    = 1'b0;
        if_rdata_s  = if_rdata_r;
        ms_rdata_s  = ms_rdata_r;
        bus_error_s = bus_error_r;
        burst_cnt_s = burst_cnt_r;
        timer_s     = timer_r;
        flushed_s   = flushed_r;
        case (state_r)
            IDLE: begin
                if (bus.ms_req && ((burst_cnt_r < BURST_MAX) || !if_pend_s)) begin
                    state_s     = BUSY_MS;
                    mem_req_s   = 1'b1;
                    mem_we_s    = bus.ms_we;
                    mem_addr_s  = bus.ms_addr;
                    mem_wdata_s = bus.ms_wdata;
                    timer_s     = {TW{1'b0}};
                    if (burst_cnt_r < BURST_MAX) begin
                        burst_cnt_s = burst_cnt_r + BW'(1);
                    end else begin
                        burst_cnt_s = burst_cnt_r;
                    end
                end else if (if_pend_s) begin
                    state_s     = BUSY_IF;
                    mem_req_s   = 1'b1;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = bus.if_addr;
                    mem_wdata_s = {WORD_WIDTH{1'b0}};
                    timer_s     = {TW{1'b0}};
                    burst_cnt_s = {BW{1'b0}};
                    flushed_s   = 1'b0;
                end else if (!bus.ms_req) begin
                    burst_cnt_s = {BW{1'b0}};
                end else begin
                    burst_cnt_s = burst_cnt_r;
                end
            end
            BUSY_IF, BUSY_MS: begin
                if (bus.mem_ack || (timer_r == TIMEOUT_LAST)) begin
                    state_s   = IDLE;
                    mem_req_s = 1'b0;
                    flushed_s = 1'b0;
                    if (!bus.mem_ack) begin
                        bus_error_s = 1'b1;
                    end else begin
                        bus_error_s = bus_error_r;
                    end
                    // A flushed fetch still finishes on the RAM but is never reported.
                    if (state_r == BUSY_MS) begin
                        ms_ack_s   = 1'b1;
                        ms_rdata_s = done_rdata_s;
                    end else if (!(flushed_r || bus.if_flush)) begin
                        if_ack_s   = 1'b1;
                        if_rdata_s = done_rdata_s;
                    end else begin
                        if_rdata_s = if_rdata_r;
                    end
                end else begin
                    timer_s = timer_r + TW'(1);
                    if ((state_r == BUSY_IF) && bus.if_flush) begin
                        flushed_s = 1'b1;
                    end else begin
                        flushed_s = flushed_r;
                    end
                end
            end
            default: begin
                state_s   = IDLE;
                mem_req_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge gclk) begin
        if (reset) begin
            state_r        <= IDLE;
            mem_req_r      <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_addr_r     <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r    <= {WORD_WIDTH{1'b0}};
            if_ack_r       <= 1'b0;
            ms_ack_r       <= 1'b0;
            if_rdata_r     <= {WORD_WIDTH{1'b0}};
            ms_rdata_r     <= {WORD_WIDTH{1'b0}};
            bus_error_r    <= 1'b0;
            burst_cnt_r    <= {BW{1'b0}};
            timer_r        <= {TW{1'b0}};
            if_kill_r      <= 1'b0;
            flushed_r      <= 1'b0;
            if_addr_prev_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r        <= state_s;
            mem_req_r      <= mem_req_s;
            mem_we_r       <= mem_we_s;
            mem_addr_r     <= mem_addr_s;
            mem_wdata_r    <= mem_wdata_s;
            if_ack_r       <= if_ack_s;
            ms_ack_r       <= ms_ack_s;
            if_rdata_r     <= if_rdata_s;
            ms_rdata_r     <= ms_rdata_s;
            bus_error_r    <= bus_error_s;
            burst_cnt_r    <= burst_cnt_s;
            timer_r        <= timer_s;
            if_kill_r      <= if_kill_s;
            flushed_r      <= flushed_s;
            if_addr_prev_r <= bus.if_addr;
        end
    end

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.if_ack    = if_ack_r;
    assign bus.ms_ack    = ms_ack_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.ms_rdata  = ms_rdata_r;
    assign bus.bus_error = bus_error_r;
    assign bus.stall     = bus.ms_req & ~ms_ack_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the RAM is driven by hand, step by step.
module tb_mem_port_arbiter;
    logic gclk;
    logic reset;
    int   checks;
    int   failures;
    int   n;
    bit   exp_if [0:5];

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .WORD_WIDTH(16)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH(32), .WORD_WIDTH(16), .MAX_MEM_BURST(4), .TIMEOUT(255)
    ) dut (
        .gclk (gclk),
        .reset(reset),
        .bus  (bus)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_if   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        reset         = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'h0;
        bus.if_flush  = 1'b0;
        bus.ms_req    = 1'b0;
        bus.ms_we     = 1'b0;
        bus.ms_addr   = 32'h0;
        bus.ms_wdata  = 16'h0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0;

        // Reset values
        tick();
        tick();
        chk1("rst_mem_req", bus.mem_req, 1'b0);
        chk1("rst_mem_we", bus.mem_we, 1'b0);
        chkw("rst_mem_addr", bus.mem_addr, 32'h0);
        chk1("rst_if_ack", bus.if_ack, 1'b0);
        chk1("rst_ms_ack", bus.ms_ack, 1'b0);
        chk1("rst_bus_error", bus.bus_error, 1'b0);
        chkw("rst_ms_rdata", 32'(bus.ms_rdata), 32'h0);
        chkw("rst_if_rdata", 32'(bus.if_rdata), 32'h0);
        reset = 1'b0;
        tick();
        chk1("idle_mem_req", bus.mem_req, 1'b0);
        chk1("idle_stall", bus.stall, 1'b0);

        // Single load, RAM acks in the second mem_req cycle
        bus.ms_req  = 1'b1;
        bus.ms_we   = 1'b0;
        bus.ms_addr = 32'h0001_0020;
        #1;
        chk1("load_stall_c1", bus.stall, 1'b1);
        tick();
        chk1("load_mem_req_c1", bus.mem_req, 1'b1);
        chkw("load_mem_addr", bus.mem_addr, 32'h0001_0020);
        chk1("load_mem_we", bus.mem_we, 1'b0);
        chk1("load_stall_c2", bus.stall, 1'b1);
        tick();
        chk1("load_mem_req_c2", bus.mem_req, 1'b1);
        chk1("load_stall_c3", bus.stall, 1'b1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hBEEF;
        tick();
        bus.mem_ack = 1'b0;
        chk1("load_ms_ack", bus.ms_ack, 1'b1);
        chkw("load_ms_rdata", 32'(bus.ms_rdata), 32'h0000_BEEF);
        chk1("load_mem_req_low", bus.mem_req, 1'b0);
        chk1("load_stall_ack", bus.stall, 1'b0);
        chk1("load_if_ack", bus.if_ack, 1'b0);
        bus.ms_req = 1'b0;
        tick();
        chk1("load_ms_ack_pulse", bus.ms_ack, 1'b0);
        chk1("load_no_regrant", bus.mem_req, 1'b0);

        // Store
        bus.ms_req   = 1'b1;
        bus.ms_we    = 1'b1;
        bus.ms_addr  = 32'h0000_0100;
        bus.ms_wdata = 16'h1234;
        tick();
        chk1("st_mem_we", bus.mem_we, 1'b1);
        chkw("st_mem_wdata", 32'(bus.mem_wdata), 32'h0000_1234);
        chkw("st_mem_addr", bus.mem_addr, 32'h0000_0100);
        tick();
        chk1("st_mem_req_hold", bus.mem_req, 1'b1);
        chk1("st_mem_we_hold", bus.mem_we, 1'b1);
        chkw("st_mem_wdata_hold", 32'(bus.mem_wdata), 32'h0000_1234);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk1("st_ms_ack", bus.ms_ack, 1'b1);
        chk1("st_if_ack", bus.if_ack, 1'b0);
        bus.ms_req = 1'b0;
        bus.ms_we  = 1'b0;
        tick();
        chk1("st_if_ack_after", bus.if_ack, 1'b0);

        // Starvation guard: both requesters held high continuously
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h0000_0200;
        bus.ms_req    = 1'b1;
        bus.ms_addr   = 32'h0000_0300;
        bus.mem_rdata = 16'h5A5A;
        for (int g = 0; g < 6; g++) begin
            tick();
            chk1("starve_mem_req", bus.mem_req, 1'b1);
            chkw("starve_grant_addr", bus.mem_addr, exp_if[g] ? 32'h0000_0200 : 32'h0000_0300);
            bus.mem_ack = 1'b1;
            tick();
            bus.mem_ack = 1'b0;
            chk1("starve_if_ack", bus.if_ack, exp_if[g]);
            chk1("starve_ms_ack", bus.ms_ack, ~exp_if[g]);
            chk1("starve_gap", bus.mem_req, 1'b0);
        end
        bus.if_req = 1'b0;
        bus.ms_req = 1'b0;
        tick();
        chkw("starve_if_rdata", 32'(bus.if_rdata), 32'h0000_5A5A);

        // Flush of an in-flight fetch
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0040;
        tick();
        chk1("fl_mem_req", bus.mem_req, 1'b1);
        chkw("fl_mem_addr", bus.mem_addr, 32'h0000_0040);
        chk1("fl_mem_we", bus.mem_we, 1'b0);
        bus.if_flush = 1'b1;
        tick();
        bus.if_flush  = 1'b0;
        bus.if_addr   = 32'h0000_0080;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        tick();
        bus.mem_ack = 1'b0;
        chk1("fl_no_if_ack", bus.if_ack, 1'b0);
        chkw("fl_if_rdata_kept", 32'(bus.if_rdata), 32'h0000_5A5A);
        chk1("fl_mem_req_low", bus.mem_req, 1'b0);
        tick();
        chk1("fl_next_grant", bus.mem_req, 1'b1);
        chkw("fl_next_addr", bus.mem_addr, 32'h0000_0080);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h7777;
        tick();
        bus.mem_ack = 1'b0;
        chk1("fl_next_if_ack", bus.if_ack, 1'b1);
        chkw("fl_next_if_rdata", 32'(bus.if_rdata), 32'h0000_7777);
        bus.if_req = 1'b0;
        tick();

        // Timeout: RAM never answers
        bus.mem_rdata = 16'hFFFF;
        bus.ms_req    = 1'b1;
        bus.ms_we     = 1'b0;
        bus.ms_addr   = 32'h0000_0500;
        tick();
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (!bus.mem_req) break;
            n++;
            tick();
        end
        chkw("to_req_cycles", 32'(n), 32'd255);
        chk1("to_bus_error", bus.bus_error, 1'b1);
        chk1("to_ms_ack", bus.ms_ack, 1'b1);
        chkw("to_ms_rdata", 32'(bus.ms_rdata), 32'h0);
        bus.ms_req = 1'b0;
        tick();
        tick();
        chk1("to_ms_ack_pulse", bus.ms_ack, 1'b0);
        chk1("to_bus_error_sticky", bus.bus_error, 1'b1);

        // Reset in the middle of a MEM transaction
        bus.ms_req  = 1'b1;
        bus.ms_addr = 32'h0000_0600;
        tick();
        chk1("rm_mem_req", bus.mem_req, 1'b1);
        reset = 1'b1;
        tick();
        chk1("rm_mem_req_low", bus.mem_req, 1'b0);
        chk1("rm_bus_error", bus.bus_error, 1'b0);
        chk1("rm_ms_ack", bus.ms_ack, 1'b0);
        chkw("rm_mem_addr", bus.mem_addr, 32'h0);
        chkw("rm_ms_rdata", 32'(bus.ms_rdata), 32'h0);
        chkw("rm_if_rdata", 32'(bus.if_rdata), 32'h0);
        reset       = 1'b0;
        bus.ms_req  = 1'b0;
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk1("spur_ms_ack", bus.ms_ack, 1'b0);
        chk1("spur_if_ack", bus.if_ack, 1'b0);
        chk1("spur_mem_req", bus.mem_req, 1'b0);
        tick();
        chk1("spur_ms_ack_late", bus.ms_ack, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
